// File: rtl/calcn_req_arbiter.sv
// calcn_req_arbiter: N-port calculator request front end.
// Per-port request FIFOs drained round-robin into one valid/ready stage.
module calcn_req_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 4,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4,
  parameter int PID_W     = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS-1:0]        req_drop,
  output logic [NUM_PORTS-1:0]        fifo_full,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PID_W-1:0]            out_port,
  output logic [CMD_W-1:0]            out_cmd,
  output logic [DATA_W-1:0]           out_data,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = PID_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PID_W-1:0] LAST = PID_W'(NUM_PORTS - 1);
  localparam logic [SW-1:0] NP = SW'(NUM_PORTS);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t mem [NUM_PORTS][DEPTH];
  req_t in_req [NUM_PORTS];
  req_t win_req;

  logic [NUM_PORTS-1:0][AW-1:0] rd_ptr;
  logic [NUM_PORTS-1:0][AW-1:0] wr_ptr;
  logic [NUM_PORTS-1:0][CW-1:0] count;
  logic [NUM_PORTS-1:0][CW-1:0] count_nxt;
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] drop;

  logic [PID_W-1:0] rr;
  logic [PID_W-1:0] win;
  logic [PID_W-1:0] cand;
  logic [SW-1:0]    sum;
  logic             found;
  logic             load;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_req[p].cmd  = req_cmd_in[p*CMD_W +: CMD_W];
      in_req[p].data = req_data_in[p*DATA_W +: DATA_W];
      in_req[p].tag  = req_tag_in[p*TAG_W +: TAG_W];
      nonempty[p]    = count[p] != '0;
    end
  end

  // Rotating priority search starting at rr, wrapping at NUM_PORTS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, rr} + SW'(i);
      if (sum >= NP)
        sum = sum - NP;
      cand = sum[PID_W-1:0];
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign load    = !out_valid || out_ready;
  assign win_req = mem[win][rd_ptr[win]];

  always_comb begin
    pop = '0;
    if (load && found)
      pop[win] = 1'b1;
  end

  // A same-cycle pop frees the slot, so a full FIFO still takes the push.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p] = !reset && in_req[p].cmd != '0
                && (count[p] != FULL || pop[p]);
      drop[p] = !reset && in_req[p].cmd != '0
                && count[p] == FULL && !pop[p];
      count_nxt[p] = count[p];
      if (push[p] && !pop[p])
        count_nxt[p] = count[p] + 1'b1;
      else if (pop[p] && !push[p])
        count_nxt[p] = count[p] - 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_full <= '0;
      req_drop  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p])
          wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])
          rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p]     <= count_nxt[p];
        fifo_full[p] <= count_nxt[p] == FULL;
      end
      req_drop <= drop;
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p])
        mem[p][wr_ptr[p]] <= in_req[p];
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_port  <= '0;
      out_cmd   <= '0;
      out_data  <= '0;
      out_tag   <= '0;
      rr        <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_port <= win;
        out_cmd  <= win_req.cmd;
        out_data <= win_req.data;
        out_tag  <= win_req.tag;
        rr       <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: doc/calcn_req_arbiter.md
Name: calcn_req_arbiter

Overview:
- Parametrised N-port request front end for the next-generation calculator.
- Each port has its own request FIFO. A round-robin arbiter drains the FIFOs into a single valid/ready output stage that feeds the shared execution pipe.
- Overflow is reported per port by dropping the request and pulsing a flag, not by silent loss.
- Generalises the fixed 4-port, 32-bit, 2-bit-tag calculator request interface in port count, data width, tag width and queue depth.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- DATA_W, 32, operand width.
- CMD_W, 4, command width; command value 0 is a no-op.
- TAG_W, 2, tag width.
- DEPTH, 4, entries per port FIFO (power of 2, >= 2).
- PID_W, 2, port-index width, equal to clog2(NUM_PORTS).

Ports:
- c_clk, input, 1, sole clock; all state updates on its posedge.
- reset, input, 1, synchronous, active-high reset.
- req_cmd_in, input, NUM_PORTS*CMD_W, per-port command; port p occupies bits [p*CMD_W : p*CMD_W+CMD_W-1].
- req_data_in, input, NUM_PORTS*DATA_W, per-port operand; same slicing rule.
- req_tag_in, input, NUM_PORTS*TAG_W, per-port tag; same slicing rule.
- req_drop, output, NUM_PORTS, one-cycle pulse per port when that port's request was discarded.
- fifo_full, output, NUM_PORTS, registered per-port full flag.
- out_valid, output, 1, output stage holds a request.
- out_ready, input, 1, downstream accepts the request when out_valid && out_ready.
- out_port, output, PID_W, index of the source port.
- out_cmd, output, CMD_W, granted command.
- out_data, output, DATA_W, granted operand.
- out_tag, output, TAG_W, granted tag.

Behaviour:
- Reset values:
  - All FIFOs empty; fifo_full=0.
  - req_drop=0.
  - out_valid=0; out_port, out_cmd, out_data and out_tag all 0.
  - Round-robin pointer = 0, so port 0 has highest priority first.
  - Inputs presented in a reset cycle are ignored.
  - Reset asserted mid-operation discards all queued and held requests.
- Push:
  - A port pushes {cmd, data, tag} at a posedge when its cmd != 0.
  - The push is refused if the FIFO is full and that FIFO is not being popped in the same cycle. A pop in the same cycle frees the slot, so the push is accepted.
  - A refused push sets req_drop[p]=1 for exactly the following cycle. The FIFO contents are unchanged.
- Load condition: the output stage is loaded when it is empty or when out_valid && out_ready.
- Arbitration (combinational over the registered FIFO non-empty flags):
  - Search starts at pointer rr and wraps modulo NUM_PORTS.
  - The first non-empty port wins, is popped, and its entry is registered into the output stage.
  - rr then becomes winner+1, wrapping to 0 after NUM_PORTS-1.
  - No load means no pop and rr is unchanged.
- Latency: a request pushed at edge k into an empty system shows out_valid=1 after edge k+1. There is no same-cycle bypass.
- Hold: while out_valid && !out_ready, all output fields are held stable. FIFOs keep accepting pushes.
- Throughput: one request per cycle when out_ready is held high.
- Ordering: per-port FIFO order is preserved. Cross-port order follows round-robin.
- Counters: each FIFO keeps read/write pointers of clog2(DEPTH) bits plus a count of clog2(DEPTH)+1 bits. Pointers wrap naturally.
- fifo_full[p] reflects the count after the current edge.

Test Plan:
- Reset then idle: all outputs 0. Port 2 sends cmd=1, data=0x0000_0005, tag=3 at edge 1 with out_ready=1 → after edge 2: out_valid=1, out_port=2, out_cmd=1, out_data=5, out_tag=3.
- All 4 ports send one request in the same cycle, out_ready=1 → grants in order 0,1,2,3 on consecutive cycles. A second burst arriving after port 1's grant starts from port 2.
- Port 0 sends 6 requests, one per cycle, with out_ready=0, DEPTH=4 → 1 request is held in the output stage and 4 fill the FIFO (fifo_full[0]=1). The 6th request gives a req_drop[0] pulse on the next cycle. Raising out_ready then drains 5 tags in order.
- Port 1 FIFO full, out_ready=1, and port 1 pushes in the same cycle as its pop → the push is accepted, no req_drop, and count stays 4.
- out_valid=1 held with out_ready=0 for 3 cycles → out_* fields are stable throughout. Asserting reset on cycle 2 → out_valid=0 and all FIFOs empty after the reset edge, with no grant afterwards.
- NUM_PORTS=8, DATA_W=64, TAG_W=4 build: port 7 request with data=0xFFFF_FFFF_FFFF_FFFF, tag=0xA → out_port=7, full 64-bit data and tag are passed through unchanged.
